data_memory_hs: RTL

DATA_MEMORY_HS -- requirements
Module: data_memory_hs

---
 rtl/data_memory_pkg.sv | 32 +++
 rtl/dmem_bank.sv | 31 +++
 rtl/data_memory_hs.sv | 114 +++++++++++
 3 files changed

// File: rtl/data_memory_pkg.sv
// Shared encodings, FSM state type and request legality helpers for the data memory.
package data_memory_pkg;

   localparam logic [2:0] MEM_B  = 3'b000;
   localparam logic [2:0] MEM_H  = 3'b001;
   localparam logic [2:0] MEM_W  = 3'b010;
   localparam logic [2:0] MEM_BU = 3'b100;
   localparam logic [2:0] MEM_HU = 3'b101;

   typedef enum logic {
      IDLE = 1'b0,
      RESP = 1'b1
   } state_t;

   // Unsigned sizes exist only for loads; the remaining codes are reserved.
   function automatic logic ctrl_ok(input logic [2:0] ctrl, input logic write);
      case (ctrl)
         MEM_B, MEM_H, MEM_W: ctrl_ok = 1'b1;
         MEM_BU, MEM_HU:      ctrl_ok = !write;
         default:             ctrl_ok = 1'b0;
      endcase
   endfunction

   function automatic logic misaligned(input logic [2:0] ctrl, input logic [1:0] addr_lo);
      case (ctrl[1:0])
         2'b01:   misaligned = addr_lo[0];
         2'b10:   misaligned = |addr_lo;
         default: misaligned = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/dmem_bank.sv
// Single-port word array with per-byte write enables and a registered read port.
// Latency: read data valid the cycle after an enabled read; writes land on the enable edge.
// Backpressure: none; rdata holds its value while en is low.
module dmem_bank #(
   parameter int DEPTH_WORDS = 256,
   localparam int AW = $clog2(DEPTH_WORDS)
) (
   input  logic          clk,
   input  logic          en,
   input  logic [3:0]    we,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] mem [DEPTH_WORDS];

   // Contents are never reset; a write cycle does not update rdata.
   always_ff @(posedge clk) begin
      if (en) begin
         if (|we) begin
            for (int b = 0; b < 4; b++) begin
               if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
         end else begin
            rdata <= mem[addr];
         end
      end
   end

endmodule

// File: rtl/data_memory_hs.sv
// Byte-addressed data memory with valid/ready request and response channels.
// Latency: one cycle from accept to resp_valid for loads, stores and faults.
// Backpressure: req_ready drops while a response is held by resp_ready=0.
module data_memory_hs
   import data_memory_pkg::*;
#(
   parameter int DEPTH_WORDS = 256,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_write,
   input  logic [2:0]       req_ctrl,
   input  logic [31:0]      req_addr,
   input  logic [31:0]      req_wdata,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [31:0]      resp_rdata,
   output logic             resp_fault,
   output logic [CNT_W-1:0] fault_count
);

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam logic [31:0] MEM_BYTES = 32'(4 * DEPTH_WORDS);

   state_t      state;
   logic        accept;
   logic        fault;
   logic        rsp_load;
   logic [2:0]  rsp_ctrl;
   logic [1:0]  rsp_off;
   logic [3:0]  be;
   logic [31:0] wlane;
   logic [31:0] word;
   logic [31:0] ext;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   assign req_ready = rst_n && ((state == IDLE) || resp_ready);
   assign accept    = req_valid && req_ready;
   assign fault     = !ctrl_ok(req_ctrl, req_write)
                    || misaligned(req_ctrl, req_addr[1:0])
                    || (req_addr >= MEM_BYTES);

   // Replicate the store data across lanes so byte enables alone pick the target.
   always_comb begin
      be    = 4'b0000;
      wlane = req_wdata;
      case (req_ctrl[1:0])
         2'b00: begin
            be    = 4'b0001 << req_addr[1:0];
            wlane = {4{req_wdata[7:0]}};
         end
         2'b01: begin
            be    = req_addr[1] ? 4'b1100 : 4'b0011;
            wlane = {2{req_wdata[15:0]}};
         end
         2'b10:   be = 4'b1111;
         default: be = 4'b0000;
      endcase
   end

   dmem_bank #(.DEPTH_WORDS(DEPTH_WORDS)) u_bank (
      .clk   (clk),
      .en    (accept && !fault),
      .we    (req_write ? be : 4'b0000),
      .addr  (req_addr[AW+1:2]),
      .wdata (wlane),
      .rdata (word)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         resp_valid  <= 1'b0;
         resp_fault  <= 1'b0;
         rsp_load    <= 1'b0;
         rsp_ctrl    <= MEM_W;
         rsp_off     <= 2'b00;
         fault_count <= '0;
      end else if (accept) begin
         state      <= RESP;
         resp_valid <= 1'b1;
         resp_fault <= fault;
         rsp_load   <= !req_write && !fault;
         rsp_ctrl   <= req_ctrl;
         rsp_off    <= req_addr[1:0];
         if (fault && (fault_count != '1)) fault_count <= fault_count + CNT_W'(1);
      end else if ((state == RESP) && resp_ready) begin
         state      <= IDLE;
         resp_valid <= 1'b0;
      end
   end

   assign byte_sel = 8'(word >> {rsp_off, 3'b000});
   assign half_sel = rsp_off[1] ? word[31:16] : word[15:0];

   always_comb begin
      ext = '0;
      case (rsp_ctrl)
         MEM_B:   ext = {{24{byte_sel[7]}}, byte_sel};
         MEM_BU:  ext = {24'd0, byte_sel};
         MEM_H:   ext = {{16{half_sel[15]}}, half_sel};
         MEM_HU:  ext = {16'd0, half_sel};
         MEM_W:   ext = word;
         default: ext = '0;
      endcase
   end

   assign resp_rdata = (resp_valid && rsp_load) ? ext : '0;

endmodule
